// File: rtl/adder_check_pkg.sv
// Shared types and default sizing for the adder lab response checker.
package adder_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    localparam int DEF_WIDTH   = 1;
    localparam int DEF_NUM_VEC = 16;
    localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/adder_golden.sv
// Golden reference adder: {exp_cout, exp_sum} = a + b + cin at WIDTH+1 bits.
module adder_golden #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] exp_sum,
    output logic             exp_cout
);

    logic [WIDTH:0] full;

    always_comb begin
        full     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        exp_sum  = full[WIDTH-1:0];
        exp_cout = full[WIDTH];
    end

endmodule

// File: rtl/adder_checker.sv
// Hardware response monitor for the adder labs: compares DUT outputs against
// the golden adder, counts vectors/mismatches and latches the first failure.
module adder_checker
    import adder_check_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_VEC = DEF_NUM_VEC,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               vec_valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    input  logic [WIDTH-1:0]   dut_sum,
    input  logic               dut_cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   vec_count,
    output logic [CNT_W-1:0]   err_count,
    output logic               err_seen,
    output logic [CNT_W-1:0]   first_err_idx,
    output logic [2*WIDTH:0]   first_err_vec
);

    chk_state_t         state_q, state_d;
    logic [CNT_W-1:0]   vec_count_q, vec_count_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic               err_seen_q, err_seen_d;
    logic [CNT_W-1:0]   first_err_idx_q, first_err_idx_d;
    logic [2*WIDTH:0]   first_err_vec_q, first_err_vec_d;
    logic               pass_q, pass_d;

    logic [WIDTH-1:0]   exp_sum;
    logic               exp_cout;
    logic               mismatch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    adder_golden #(.WIDTH(WIDTH)) u_golden (
        .a        (a),
        .b        (b),
        .cin      (cin),
        .exp_sum  (exp_sum),
        .exp_cout (exp_cout)
    );

    // Four-state compare so an X/Z on the DUT side reads as a mismatch in
    // simulation; synthesis treats it as a plain inequality.
    always_comb begin
        mismatch = ({dut_cout, dut_sum} !== {exp_cout, exp_sum});
    end

    always_comb begin
        state_d         = state_q;
        vec_count_d     = vec_count_q;
        err_count_d     = err_count_q;
        err_seen_d      = err_seen_q;
        first_err_idx_d = first_err_idx_q;
        first_err_vec_d = first_err_vec_q;
        pass_d          = pass_q;

        if (start) begin
            // start wins over stop and restarts a run from any state
            state_d         = RUN;
            vec_count_d     = '0;
            err_count_d     = '0;
            err_seen_d      = 1'b0;
            first_err_idx_d = '0;
            first_err_vec_d = '0;
            pass_d          = 1'b0;
        end else if (state_q == RUN) begin
            if (vec_valid) begin
                vec_count_d = sat_inc(vec_count_q);
                if (mismatch) begin
                    err_count_d = sat_inc(err_count_q);
                    if (!err_seen_q) begin
                        err_seen_d      = 1'b1;
                        first_err_idx_d = vec_count_q;
                        first_err_vec_d = {a, b, cin};
                    end
                end
            end
            // the vector in this cycle is already folded in before completing
            if (stop || (vec_valid && (32'(vec_count_d) == 32'(NUM_VEC)))) begin
                state_d = DONE;
                pass_d  = (err_count_d == '0) && (vec_count_d != '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            vec_count_q     <= '0;
            err_count_q     <= '0;
            err_seen_q      <= 1'b0;
            first_err_idx_q <= '0;
            first_err_vec_q <= '0;
            pass_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            vec_count_q     <= vec_count_d;
            err_count_q     <= err_count_d;
            err_seen_q      <= err_seen_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_vec_q <= first_err_vec_d;
            pass_q          <= pass_d;
        end
    end

    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign pass          = pass_q;
    assign vec_count     = vec_count_q;
    assign err_count     = err_count_q;
    assign err_seen      = err_seen_q;
    assign first_err_idx = first_err_idx_q;
    assign first_err_vec = first_err_vec_q;

endmodule
